mips_register_file: RTL and testbench
=====================================

Name: mips_register_file

Overview:
- General-purpose register file for the single-cycle MIPS datapath: 32 registers of 32 bits each.
- Two combinational read ports (rs/rt operands) and one synchronous write port (rd/rt result).
- Register 0 is hardwired to zero, per MIPS convention.
- Sits between instruction decode and the ALU; the write port is driven by the writeback mux.

Parameters:
- DATA_WIDTH, 32, width of each register and of the WD3/RD1/RD2 data buses.
- ADDR_WIDTH, 5, width of the A1/A2/A3 address buses; depth = 2**ADDR_WIDTH registers.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- A1  input  ADDR_WIDTH  read address, port 1.
- A2  input  ADDR_WIDTH  read address, port 2.
- A3  input  ADDR_WIDTH  write address.
- WE3  input  1  write enable, active high.
- WD3  input  DATA_WIDTH  write data.
- RD1  output  DATA_WIDTH  read data, port 1.
- RD2  output  DATA_WIDTH  read data, port 2.

Behaviour:
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits.

Reset:
- Reset is synchronous and active-low: on a rising clk edge with rst_n=0, all registers clear to 0.
- Reset has priority over a simultaneous write; the write is discarded.
- While rst_n is low, RD1/RD2 read back 0 once the first reset edge has occurred.
- Before the first reset edge, register contents (except register 0) are unspecified.

Write:
- On a rising clk edge with rst_n=1, WE3=1 and A3≠0: register[A3] <= WD3.
- WE3=0: no register changes.
- A3=0: the write is silently ignored; register 0 always holds 0.
- Exactly one write per cycle; latency is 1 edge.

Read:
- RD1 = register[A1] and RD2 = register[A2], purely combinational with no clock latency.
- A1=0 or A2=0 always yields 0, independent of reset state or any write attempt.
- Both ports may address the same register, including A1=A2=A3. Each returns the same value.

Read-during-write to the same address:
- There is no internal bypass.
- Before the edge, the read returns the old value; after the edge, it returns WD3.
- This is the required single-cycle MIPS behaviour: write at the edge, read in the following cycle.

Other requirements:
- No X propagation on RD1/RD2 for in-range addresses after reset. All address values are in range by construction.
- No other outputs, status flags or handshakes.

Test Plan:
- Reset: write 32'hDEADBEEF to registers 1..31. Pulse rst_n=0 for one edge, then read all 31 registers -> RD1=RD2=0 for every address.
- Sequential fill: after reset, with WE3=1 on consecutive edges, write WD3=k+1 to A3=k for k=1..16, setting A1=A2=k after each edge. Required: RD1=RD2=k+1, e.g. register 5 reads 6 and register 16 reads 17.
- Register 0 protection: write A3=0, WD3=32'hFFFFFFFF, WE3=1, then read A1=0 -> RD1=0. Also drive WE3=1, A3=0 and rst_n=1 every cycle -> register 0 never nonzero.
- Write-enable gating: register 7 holds 8. Apply A3=7, WD3=32'h12345678, WE3=0 for one edge -> RD1 with A1=7 still reads 8.
- Dual read / read-during-write: A1=3, A2=9 with stored values 4 and 10 -> RD1=4, RD2=10 in the same cycle. Then set A3=A1=3, WD3=32'hA5A5A5A5, WE3=1: RD1=4 before the edge and 32'hA5A5A5A5 after it.
- Reset vs write collision: rst_n=0 with WE3=1, A3=12, WD3=32'h55 on the same edge -> register 12 reads 0 afterwards.

Source files
------------

// File: rtl/mips_register_file.sv
// Register file for a single-cycle MIPS datapath: two combinational read ports, one write port.
// Writes land on the rising edge with no bypass; register 0 reads zero and has no storage.
module mips_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic                  WE3,
  input  logic [DATA_WIDTH-1:0] WD3,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [1:DEPTH-1];
  logic [DATA_WIDTH-1:0] regs_d [1:DEPTH-1];
  logic [DATA_WIDTH-1:0] rf_view [0:DEPTH-1];

  // Address 0 never matches the decode, so writes to it fall away.
  always_comb begin
    for (int i = 1; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (WE3 && (A3 == ADDR_WIDTH'(i))) begin
        regs_d[i] = WD3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    rf_view[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      rf_view[i] = regs_q[i];
    end
  end

  assign RD1 = rf_view[A1];
  assign RD2 = rf_view[A2];

endmodule

// File: tb/tb_mips_register_file.sv
// Randomised and directed checks of mips_register_file against an array model.
module tb_mips_register_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  A1, A2, A3;
  logic        WE3;
  logic [31:0] WD3;
  logic [31:0] RD1, RD2;

  logic [31:0] model [0:31];
  int          n_checks;
  int          n_errs;

  mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A1   (A1),
    .A2   (A2),
    .A3   (A3),
    .WE3  (WE3),
    .WD3  (WD3),
    .RD1  (RD1),
    .RD2  (RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Model the edge using the currently driven inputs, then take the edge.
  task automatic tick();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (WE3 && A3 != 5'd0) begin
      model[A3] = WD3;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    A1 = a1;
    A2 = a2;
    #1;
    check_val({tag, "_rd1"}, RD1, model[a1]);
    check_val({tag, "_rd2"}, RD2, model[a2]);
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst_n = 1'b1; A1 = '0; A2 = '0; A3 = '0; WE3 = 1'b0; WD3 = '0;
    @(posedge clk);
    #1;

    // Register 0 reads zero even before any reset edge
    read_check("pre_reset_r0", 5'd0, 5'd0);

    // Fill 1..31 with DEADBEEF, then reset
    WE3 = 1'b1;
    WD3 = 32'hDEADBEEF;
    for (int k = 1; k < 32; k++) begin
      A3 = 5'(k);
      tick();
    end
    WE3 = 1'b0;
    read_check("fill_dead", 5'd17, 5'd31);
    check_val("fill_dead_const", RD1, 32'hDEADBEEF);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k < 32; k++) begin
      A1 = 5'(k);
      A2 = 5'(k);
      #1;
      check_val("reset_clear_rd1", RD1, 32'h0);
      check_val("reset_clear_rd2", RD2, 32'h0);
    end

    // Sequential fill: reg k gets k+1
    WE3 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      A3  = 5'(k);
      WD3 = 32'(k + 1);
      tick();
      A1 = 5'(k);
      A2 = 5'(k);
      #1;
      check_val("seq_fill_rd1", RD1, 32'(k + 1));
      check_val("seq_fill_rd2", RD2, 32'(k + 1));
    end

    // Register 0 protection
    A3  = 5'd0;
    WD3 = 32'hFFFFFFFF;
    tick();
    A1 = 5'd0;
    #1;
    check_val("r0_write_ignored", RD1, 32'h0);
    for (int c = 0; c < 20; c++) begin
      WD3 = $urandom;
      tick();
      check_val("r0_hammer", RD1, 32'h0);
    end

    // Write-enable gating
    A3  = 5'd7;
    WD3 = 32'h12345678;
    WE3 = 1'b0;
    tick();
    A1 = 5'd7;
    #1;
    check_val("we_gating", RD1, 32'd8);

    // Dual read and read-during-write
    A1 = 5'd3;
    A2 = 5'd9;
    #1;
    check_val("dual_rd1", RD1, 32'd4);
    check_val("dual_rd2", RD2, 32'd10);
    A3  = 5'd3;
    WD3 = 32'hA5A5A5A5;
    WE3 = 1'b1;
    #1;
    check_val("rdw_before", RD1, 32'd4);
    tick();
    check_val("rdw_after", RD1, 32'hA5A5A5A5);
    A2 = 5'd3;
    #1;
    check_val("same_addr_rd2", RD2, 32'hA5A5A5A5);

    // Reset beats a simultaneous write, and reads stay zero while held
    A3  = 5'd12;
    WD3 = 32'h55;
    WE3 = 1'b1;
    rst_n = 1'b0;
    tick();
    A1 = 5'd12;
    A2 = 5'd3;
    #1;
    check_val("rst_collision", RD1, 32'h0);
    check_val("rst_held_rd2", RD2, 32'h0);
    rst_n = 1'b1;
    WE3 = 1'b0;
    tick();
    check_val("rst_collision_after", RD1, 32'h0);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      WE3   = $urandom_range(0, 3) != 0;
      A3    = 5'($urandom_range(0, 31));
      WD3   = $urandom;
      A1    = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom_range(0, 31));
      A2    = 5'($urandom_range(0, 31));
      #1;
      check_val("rand_rd1", RD1, model[A1]);
      check_val("rand_rd2", RD2, model[A2]);
      tick();
      check_val("rand_post_rd1", RD1, model[A1]);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
